// File: rtl/ffd_reg.sv
// Parameterised enabled D register with asynchronous active-low reset.
// Define FFD_SYNC_CLR_EN to add a synchronous clear input (clr).
module ffd_reg #(
  parameter int unsigned WIDTH       = 4,
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
`ifdef FFD_SYNC_CLR_EN
  input  logic             clr,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Catch configurations that would silently truncate or produce a zero-width register.
  if (WIDTH == 0 || WIDTH > 64) begin : g_bad_width
    $error("ffd_reg: WIDTH=%0d outside legal range 1..64", WIDTH);
  end
  if ((RESET_VALUE >> WIDTH) != 64'd0) begin : g_bad_reset_value
    $error("ffd_reg: RESET_VALUE 0x%0h does not fit in WIDTH=%0d bits", RESET_VALUE, WIDTH);
  end

  localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; a blocking assignment here would create ordering races between flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RST_Q;
`ifdef FFD_SYNC_CLR_EN
    end else if (clr) begin
      q <= RST_Q;
`endif
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_ffd_reg.sv
// Self-checking bench for ffd_reg: WIDTH=1,2,4 instances side by side, directed
// steps followed by randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_ffd_reg;

`ifdef FFD_SYNC_CLR_EN
  localparam bit HAS_CLR = 1'b1;
`else
  localparam bit HAS_CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic       d1;
  logic [1:0] d2;
  logic [3:0] d4;
  logic       q1;
  logic [1:0] q2;
  logic [3:0] q4;

  // Model: each register shows the last value loaded since the most recent reset or clear.
  logic       m1;
  logic [1:0] m2;
  logic [3:0] m4;

  int n_checks = 0;
  int n_errors = 0;

  always #1 clk = ~clk;

  ffd_reg #(.WIDTH(1), .RESET_VALUE(64'd0)) u_w1 (
    .clk(clk), .reset(reset), .en(en),
`ifdef FFD_SYNC_CLR_EN
    .clr(clr),
`endif
    .d(d1), .q(q1)
  );

  ffd_reg #(.WIDTH(2), .RESET_VALUE(64'd0)) u_w2 (
    .clk(clk), .reset(reset), .en(en),
`ifdef FFD_SYNC_CLR_EN
    .clr(clr),
`endif
    .d(d2), .q(q2)
  );

  ffd_reg #(.WIDTH(4), .RESET_VALUE(64'd0)) u_w4 (
    .clk(clk), .reset(reset), .en(en),
`ifdef FFD_SYNC_CLR_EN
    .clr(clr),
`endif
    .d(d4), .q(q4)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/w1"}, {3'b000, q1}, {3'b000, m1});
    check({tag, "/w2"}, {2'b00, q2}, {2'b00, m2});
    check({tag, "/w4"}, q4, m4);
  endtask

  task automatic model_clear();
    m1 = 1'b0;
    m2 = 2'b00;
    m4 = 4'b0000;
  endtask

  // Model view of one rising edge, evaluated with the inputs present at that edge.
  task automatic model_edge();
    if (reset !== 1'b1 || (HAS_CLR && clr === 1'b1)) begin
      model_clear();
    end else if (en === 1'b1) begin
      m1 = d1;
      m2 = d2;
      m4 = d4;
    end
  endtask

  // One clock: update model at the rising edge, compare on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic e, input logic v1, input logic [1:0] v2, input logic [3:0] v4);
    en = e;
    d1 = v1;
    d2 = v2;
    d4 = v4;
  endtask

  task automatic async_reset_now(input string tag);
    #0.5 reset = 1'b0;
    model_clear();
    #0.1 check_all(tag);
  endtask

  initial begin
    // 1. Reset with en=0: q is 0 immediately and stays 0 across edges.
    clr   = 1'b0;
    reset = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    model_clear();
    #0.5 check_all("rst_immediate");
    repeat (2) tick("rst_hold");

    // 2. Reset with enable asserted: still 0.
    drive(1'b1, 1'b1, 2'b11, 4'b1011);
    repeat (2) tick("rst_with_en");

    // An X on en while in reset must not disturb q.
    en = 1'bx;
    tick("rst_en_x");
    en = 1'b1;

    // Release reset between edges: release alone must not load.
    reset = 1'b1;
    #0.3 check_all("release_no_load");

    // 3. Load on the next rising edge.
    tick("load");

    // 4. Hold with en=0 and different d.
    drive(1'b0, 1'b0, 2'b01, 4'b0011);
    repeat (3) tick("hold");

    // Load a distinct pattern, then reload the original one.
    drive(1'b1, 1'b0, 2'b10, 4'b0110);
    tick("load_alt");
    drive(1'b1, 1'b1, 2'b11, 4'b1011);
    tick("reload");

    // 5. Drop reset mid-cycle: q clears before any edge; pending load is lost.
    async_reset_now("async_clear");
    tick("async_hold");
    reset = 1'b1;
    drive(1'b0, 1'b1, 2'b11, 4'b1011);
    tick("post_release_hold");
    en = 1'b1;
    tick("post_release_load");

`ifdef FFD_SYNC_CLR_EN
    // 6. Synchronous clear overrides enable; no effect between edges.
    clr = 1'b1;
    #0.3 check_all("clr_no_async_effect");
    tick("clr_overrides_en");
    clr = 1'b0;
    tick("clr_released_load");
`endif

    // Randomized traffic, including occasional mid-cycle resets.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
      clr = HAS_CLR && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        async_reset_now("rand_async");
      end else begin
        reset = ($urandom_range(0, 29) != 0);
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
